// File: rtl/regfile_mp.sv
// regfile_mp: parametrised architectural register file with two write ports
// and two registered read ports.
//
// Parameters
//   DATA_W   register width in bits (multiple of 8); NB = DATA_W/8 byte lanes
//   DEPTH    number of registers (2..256)
//   ZERO_REG 1 = register 0 is hard-wired to zero
//   BYPASS   1 = a read sees same-cycle writes; 0 = a read sees pre-write contents
//
// Ports
//   clk                          rising-edge clock
//   rst                          asynchronous active-high reset (storage and read data)
//   we0/waddr0/wdata0/wbe0       write port 0 (byte-enabled)
//   we1/waddr1/wdata1/wbe1       write port 1 (byte-enabled, wins collisions per lane)
//   re0/raddr0 -> rdata0         read port 0, one-cycle registered, holds while re0=0
//   re1/raddr1 -> rdata1         read port 1, same behaviour as port 0
module regfile_mp #(
  parameter  int DATA_W   = 16,
  parameter  int DEPTH    = 16,
  parameter  bit ZERO_REG = 1'b0,
  parameter  bit BYPASS   = 1'b1,
  localparam int NB       = DATA_W / 8,
  localparam int ADDR_W   = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [NB-1:0]     wbe0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [NB-1:0]     wbe1,
  input  logic              re0,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  // Expand byte enables into a bit mask and merge the enabled lanes of wdata over old.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] wdata_v,
    input logic [NB-1:0]     be_v
  );
    logic [DATA_W-1:0] mask_v;
    mask_v = '0;
    for (int i = 0; i < NB; i++) begin
      mask_v[8*i +: 8] = {8{be_v[i]}};
    end
    return (old_v & ~mask_v) | (wdata_v & mask_v);
  endfunction

  // Next storage state. Port 0 is merged first and port 1 on top of it, so on
  // an address collision port 1 owns every lane it enables. Addresses at or
  // beyond DEPTH match no entry, which drops those writes. With ZERO_REG the
  // entry 0 is pinned to zero, so every read of it (bypassed or not) is zero.
  always_comb begin
    mem_d = mem_q;
    for (int e = 0; e < DEPTH; e++) begin
      mem_d[e] = (ZERO_REG && (e == 0)) ? {DATA_W{1'b0}} :
                 merge_bytes(
                   merge_bytes(mem_q[e], wdata0,
                               (we0 && (waddr0 == ADDR_W'(e))) ? wbe0 : {NB{1'b0}}),
                   wdata1,
                   (we1 && (waddr1 == ADDR_W'(e))) ? wbe1 : {NB{1'b0}});
    end
  end

  // Read muxes: AND-OR select so an out-of-range address yields zero. Bypass
  // selects the post-write image, which is exactly what a later read returns.
  always_comb begin
    rdata0_d = '0;
    rdata1_d = '0;
    for (int e = 0; e < DEPTH; e++) begin
      rdata0_d = rdata0_d | ({DATA_W{raddr0 == ADDR_W'(e)}} & (BYPASS ? mem_d[e] : mem_q[e]));
      rdata1_d = rdata1_d | ({DATA_W{raddr1 == ADDR_W'(e)}} & (BYPASS ? mem_d[e] : mem_q[e]));
    end
  end

  // Storage and read-data registers; read data only reloads when its enable is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem_q[e] <= '0;
      end
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      mem_q <= mem_d;
      if (re0) begin
        rdata0_q <= rdata0_d;
      end else begin
        rdata0_q <= rdata0_q;
      end
      if (re1) begin
        rdata1_q <= rdata1_d;
      end else begin
        rdata1_q <= rdata1_q;
      end
    end
  end

  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two instances share one stimulus stream:
//   A: DEPTH=16, ZERO_REG=0, BYPASS=1
//   B: DEPTH=12, ZERO_REG=1, BYPASS=0
// Each table row carries one cycle of inputs and the hand-derived read data
// both instances must show after that cycle's rising edge.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, re0, re1;
  logic [3:0]  waddr0, waddr1, raddr0, raddr1;
  logic [15:0] wdata0, wdata1;
  logic [1:0]  wbe0, wbe1;
  logic [15:0] a_rdata0, a_rdata1, b_rdata0, b_rdata1;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        we0;
    logic [3:0]  wa0;
    logic [15:0] wd0;
    logic [1:0]  be0;
    logic        we1;
    logic [3:0]  wa1;
    logic [15:0] wd1;
    logic [1:0]  be1;
    logic        re0;
    logic [3:0]  ra0;
    logic        re1;
    logic [3:0]  ra1;
    logic [15:0] ea0, ea1, eb0, eb1;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] a0, a1, b0, b1;
  } exp_t;

  vec_t tbl [20];
  exp_t sb [$];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(16), .DEPTH(16), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut_a (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .re0(re0), .raddr0(raddr0), .rdata0(a_rdata0),
    .re1(re1), .raddr1(raddr1), .rdata1(a_rdata1)
  );

  regfile_mp #(.DATA_W(16), .DEPTH(12), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .wbe0(wbe0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1), .wbe1(wbe1),
    .re0(re0), .raddr0(raddr0), .rdata0(b_rdata0),
    .re1(re1), .raddr1(raddr1), .rdata1(b_rdata1)
  );

  function automatic vec_t mk(
    input logic w0, input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] b0,
    input logic w1, input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] b1,
    input logic r0, input logic [3:0] q0, input logic r1, input logic [3:0] q1,
    input logic [15:0] x0, input logic [15:0] x1, input logic [15:0] y0, input logic [15:0] y1
  );
    vec_t v;
    v.we0 = w0; v.wa0 = a0; v.wd0 = d0; v.be0 = b0;
    v.we1 = w1; v.wa1 = a1; v.wd1 = d1; v.be1 = b1;
    v.re0 = r0; v.ra0 = q0; v.re1 = r1; v.ra1 = q1;
    v.ea0 = x0; v.ea1 = x1; v.eb0 = y0; v.eb1 = y1;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, id, act, want);
    end
  endtask

  task automatic idle_inputs();
    we0 = 1'b0; waddr0 = 4'h0; wdata0 = 16'h0000; wbe0 = 2'b00;
    we1 = 1'b0; waddr1 = 4'h0; wdata1 = 16'h0000; wbe1 = 2'b00;
    re0 = 1'b0; raddr0 = 4'h0; re1 = 1'b0; raddr1 = 4'h0;
  endtask

  // Drive one row, queue its expectation, then pop and compare 1 time unit after the edge.
  task automatic drive_cycle(input vec_t v, input int id);
    exp_t e;
    we0 = v.we0; waddr0 = v.wa0; wdata0 = v.wd0; wbe0 = v.be0;
    we1 = v.we1; waddr1 = v.wa1; wdata1 = v.wd1; wbe1 = v.be1;
    re0 = v.re0; raddr0 = v.ra0; re1 = v.re1; raddr1 = v.ra1;
    e.id = id; e.a0 = v.ea0; e.a1 = v.ea1; e.b0 = v.eb0; e.b1 = v.eb1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty[%0d] got=0 want=1", id);
    end else begin
      e = sb.pop_front();
      chk("a_rdata0", e.id, a_rdata0, e.a0);
      chk("a_rdata1", e.id, a_rdata1, e.a1);
      chk("b_rdata0", e.id, b_rdata0, e.b0);
      chk("b_rdata1", e.id, b_rdata1, e.b1);
    end
  endtask

  initial begin
    // Rows: write port 0 | write port 1 | reads | expected A0 A1 B0 B1
    tbl[0]  = mk(1'b1,4'h0,16'hAAAA,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,1'b0,4'h0, 16'h0000,16'h0000,16'h0000,16'h0000);
    tbl[1]  = mk(1'b1,4'h1,16'h5555,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h0,1'b1,4'h1, 16'hAAAA,16'h5555,16'h0000,16'h0000);
    tbl[2]  = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h0,1'b1,4'h1, 16'hAAAA,16'h5555,16'h0000,16'h5555);
    tbl[3]  = mk(1'b1,4'h2,16'h1234,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,1'b0,4'h0, 16'hAAAA,16'h5555,16'h0000,16'h5555);
    tbl[4]  = mk(1'b1,4'h2,16'hABCD,2'b10, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h2,1'b0,4'h0, 16'hAB34,16'h5555,16'h1234,16'h5555);
    tbl[5]  = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h2,1'b0,4'h0, 16'hAB34,16'h5555,16'hAB34,16'h5555);
    tbl[6]  = mk(1'b1,4'h3,16'h1111,2'b11, 1'b1,4'h3,16'h2222,2'b01, 1'b0,4'h0,1'b1,4'h3, 16'hAB34,16'h1122,16'hAB34,16'h0000);
    tbl[7]  = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,1'b1,4'h3, 16'hAB34,16'h1122,16'hAB34,16'h1122);
    tbl[8]  = mk(1'b1,4'h4,16'hF0F0,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h4,1'b0,4'h0, 16'hF0F0,16'h1122,16'h0000,16'h1122);
    tbl[9]  = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h4,1'b0,4'h0, 16'hF0F0,16'h1122,16'hF0F0,16'h1122);
    tbl[10] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h1,1'b0,4'h0, 16'h5555,16'h1122,16'h5555,16'h1122);
    tbl[11] = mk(1'b1,4'h1,16'h0F0F,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h1,1'b0,4'h0, 16'h5555,16'h1122,16'h5555,16'h1122);
    tbl[12] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h1,1'b0,4'h0, 16'h5555,16'h1122,16'h5555,16'h1122);
    tbl[13] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h1,1'b0,4'h0, 16'h0F0F,16'h1122,16'h0F0F,16'h1122);
    tbl[14] = mk(1'b1,4'hD,16'hBEEF,2'b11, 1'b1,4'hC,16'hCAFE,2'b11, 1'b1,4'hD,1'b1,4'hC, 16'hBEEF,16'hCAFE,16'h0000,16'h0000);
    tbl[15] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'hD,1'b1,4'hC, 16'hBEEF,16'hCAFE,16'h0000,16'h0000);
    tbl[16] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'hB,1'b1,4'h0, 16'h0000,16'hAAAA,16'h0000,16'h0000);
    tbl[17] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h1,1'b1,4'h5, 16'h0F0F,16'h0000,16'h0F0F,16'h0000);
    tbl[18] = mk(1'b1,4'h6,16'hFFFF,2'b00, 1'b1,4'h6,16'hFFFF,2'b00, 1'b1,4'h6,1'b0,4'h0, 16'h0000,16'h0000,16'h0000,16'h0000);
    tbl[19] = mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h3,1'b1,4'h3, 16'h1122,16'h1122,16'h1122,16'h1122);

    // Power-up reset: read data must be zero while reset is held.
    rst = 1'b1;
    idle_inputs();
    #12;
    chk("reset_a0", 0, a_rdata0, 16'h0000);
    chk("reset_b1", 0, b_rdata1, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // Load non-zero data into r5 and both read registers, then reset mid-cycle.
    drive_cycle(mk(1'b1,4'h5,16'h7777,2'b11, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h5,1'b0,4'h0,
                   16'h7777,16'h0000,16'h0000,16'h0000), 100);
    drive_cycle(mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h5,1'b1,4'h5,
                   16'h7777,16'h7777,16'h7777,16'h7777), 101);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_a0", 102, a_rdata0, 16'h0000);
    chk("async_rst_a1", 102, a_rdata1, 16'h0000);
    chk("async_rst_b0", 102, b_rdata0, 16'h0000);
    chk("async_rst_b1", 102, b_rdata1, 16'h0000);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive_cycle(tbl[i], i);
    end

    // A write that meets the edge at which reset is raised must be lost.
    we0 = 1'b1; waddr0 = 4'h7; wdata0 = 16'h1234; wbe0 = 2'b11;
    re0 = 1'b1; raddr0 = 4'h3; re1 = 1'b1; raddr1 = 4'h3;
    #3;
    rst = 1'b1;
    #3;
    chk("rst_edge_a0", 200, a_rdata0, 16'h0000);
    chk("rst_edge_b1", 200, b_rdata1, 16'h0000);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    drive_cycle(mk(1'b0,4'h0,16'h0000,2'b00, 1'b0,4'h0,16'h0000,2'b00, 1'b1,4'h7,1'b1,4'h3,
                   16'h0000,16'h0000,16'h0000,16'h0000), 201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
